// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, FSM states,
// datapath select codes and the instruction-class flags handed from decoder to FSM.
package mc_ctrl_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_B    = 3'd2;
    localparam logic [2:0] IMM_S    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_U    = 3'd5;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_PC4 = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_ALU    = 2'b01;
    localparam logic [1:0] PC_ALU_AL = 2'b10;

    typedef enum logic [2:0] {
        ST_IF,
        ST_ID,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic jal;
        logic jalr;
        logic branch;
        logic load;
        logic store;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Bus between the control unit (master) and the IR/PC registers, memories and
// datapath muxes (slave).
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ir;
    logic             imem_rdy;
    logic             dmem_rdy;
    logic             br_taken;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic             op1_sel;
    logic             op2_sel;
    logic [3:0]       alu_ctrl;
    logic [2:0]       imm_type;
    logic             br_en;
    logic [2:0]       br_f3;
    logic             halt;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] instret;

    modport master (
        input  ir, imem_rdy, dmem_rdy, br_taken,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
               op1_sel, op2_sel, alu_ctrl, imm_type, br_en, br_f3, halt, illegal,
               bus_err, instret
    );

    modport slave (
        output ir, imem_rdy, dmem_rdy, br_taken,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
               op1_sel, op2_sel, alu_ctrl, imm_type, br_en, br_f3, halt, illegal,
               bus_err, instret
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational RV32I decode: instruction class flags for the FSM plus the
// datapath selects (ALU op, immediate format, operand and write-back muxes).
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       f7b5,
    output iclass_t    cls,
    output logic [3:0] alu_ctrl,
    output logic [2:0] imm_type,
    output logic [1:0] wb_sel,
    output logic       op1_sel,
    output logic       op2_sel
);

    always_comb begin
        cls      = '0;
        alu_ctrl = ALU_ADD;
        imm_type = IMM_NONE;
        wb_sel   = WB_ALU;
        op1_sel  = 1'b0;
        op2_sel  = 1'b1;
        case (opcode)
            OPC_OP: begin
                op2_sel  = 1'b0;
                alu_ctrl = {f7b5, funct3};
            end
            OPC_OP_IMM: begin
                imm_type = IMM_I;
                // funct7[5] only distinguishes SRLI/SRAI; elsewhere it is immediate bits
                alu_ctrl = {f7b5 & (funct3 == 3'b101), funct3};
            end
            OPC_LOAD: begin
                cls.load = 1'b1;
                imm_type = IMM_I;
                wb_sel   = WB_MEM;
            end
            OPC_STORE: begin
                cls.store = 1'b1;
                imm_type  = IMM_S;
            end
            OPC_BRANCH: begin
                cls.branch = 1'b1;
                op1_sel    = 1'b1;
                imm_type   = IMM_B;
            end
            OPC_JAL: begin
                cls.jal  = 1'b1;
                op1_sel  = 1'b1;
                imm_type = IMM_J;
                wb_sel   = WB_PC4;
            end
            OPC_JALR: begin
                cls.jalr = 1'b1;
                imm_type = IMM_I;
                wb_sel   = WB_PC4;
            end
            OPC_LUI: begin
                imm_type = IMM_U;
                wb_sel   = WB_IMM;
            end
            OPC_AUIPC: begin
                op1_sel  = 1'b1;
                imm_type = IMM_U;
            end
            OPC_MISC_MEM, OPC_SYSTEM: ;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/HALT) with memory-wait watchdog,
// sticky halt causes and retired-instruction counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic      clk,
    input  logic      rstn,
    mc_ctrl_if.master bus
);

    localparam int WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_e           state;
    logic             run;
    logic [WC_W-1:0]  wait_cnt;
    logic [CNT_W-1:0] instret;
    logic             illegal_q;
    logic             bus_err_q;
    iclass_t          cls;
    logic             wd_expire;
    logic             in_if;
    logic             in_ex;
    logic             ex_jump;

    mc_ctrl_decode u_decode (
        .opcode   (bus.ir[6:0]),
        .funct3   (bus.ir[14:12]),
        .f7b5     (bus.ir[30]),
        .cls      (cls),
        .alu_ctrl (bus.alu_ctrl),
        .imm_type (bus.imm_type),
        .wb_sel   (bus.wb_sel),
        .op1_sel  (bus.op1_sel),
        .op2_sel  (bus.op2_sel)
    );

    assign wd_expire = (TIMEOUT != 0) && (wait_cnt == WC_W'(TIMEOUT));

    // run holds IF strobes low through reset and the release cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IF;
            run       <= 1'b0;
            wait_cnt  <= '0;
            instret   <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_IF: begin
                    if (run) begin
                        if (bus.imem_rdy) begin
                            state    <= ST_ID;
                            wait_cnt <= '0;
                        end else if (wd_expire) begin
                            state     <= ST_HALT;
                            bus_err_q <= 1'b1;
                            wait_cnt  <= '0;
                        end else if (TIMEOUT != 0) begin
                            wait_cnt <= wait_cnt + WC_W'(1);
                        end
                    end
                end
                ST_ID: begin
                    if (bus.ir == INSN_EBREAK) begin
                        state <= ST_HALT;
                    end else if (cls.illegal) begin
                        state     <= ST_HALT;
                        illegal_q <= 1'b1;
                    end else begin
                        state <= ST_EX;
                    end
                end
                ST_EX: begin
                    if (cls.branch) begin
                        state   <= ST_IF;
                        instret <= instret + CNT_W'(1);
                    end else if (cls.load || cls.store) begin
                        state <= ST_MEM;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (bus.dmem_rdy) begin
                        wait_cnt <= '0;
                        if (cls.store) begin
                            state   <= ST_IF;
                            instret <= instret + CNT_W'(1);
                        end else begin
                            state <= ST_WB;
                        end
                    end else if (wd_expire) begin
                        state     <= ST_HALT;
                        bus_err_q <= 1'b1;
                        wait_cnt  <= '0;
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                ST_WB: begin
                    state   <= ST_IF;
                    instret <= instret + CNT_W'(1);
                end
                ST_HALT: ;
                default: state <= ST_HALT;
            endcase
        end
    end

    assign in_if   = run && (state == ST_IF);
    assign in_ex   = (state == ST_EX);
    assign ex_jump = cls.jal || cls.jalr || (cls.branch && bus.br_taken);

    assign bus.imem_req = in_if;
    assign bus.ir_we    = in_if && bus.imem_rdy;
    assign bus.pc_we    = (in_if && bus.imem_rdy) || (in_ex && ex_jump);
    assign bus.pc_sel   = !(in_ex && ex_jump) ? PC_PLUS4 :
                          cls.jalr            ? PC_ALU_AL : PC_ALU;
    assign bus.dmem_req = (state == ST_MEM);
    assign bus.dmem_we  = (state == ST_MEM) && cls.store;
    assign bus.rf_we    = (state == ST_WB);
    assign bus.br_en    = in_ex && cls.branch;
    assign bus.br_f3    = bus.ir[14:12];
    assign bus.halt     = (state == ST_HALT);
    assign bus.illegal  = illegal_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.instret  = instret;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed and randomized bench for mc_ctrl: expected per-cycle strobes come from an
// instruction-level schedule built from the architectural phase rules.
module tb_mc_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(32)) bus ();

    mc_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic       irdy;
        logic       drdy;
        logic       ex;
        logic [9:0] stb;
    } cyc_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_instret;

    logic [6:0] opcs [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] mk(input logic req, input logic irwe, input logic pcwe,
                                      input logic [1:0] psel, input logic dreq, input logic dwe,
                                      input logic rfwe, input logic bren, input logic hlt);
        return {req, irwe, pcwe, psel, dreq, dwe, rfwe, bren, hlt};
    endfunction

    function automatic logic [9:0] stb();
        return {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_sel, bus.dmem_req, bus.dmem_we,
                bus.rf_we, bus.br_en, bus.halt};
    endfunction

    function automatic logic [14:0] dec_obs();
        return {bus.op1_sel, bus.op2_sel, bus.alu_ctrl, bus.imm_type, bus.wb_sel, bus.br_f3};
    endfunction

    // Decode table: {op1_sel, op2_sel, alu_ctrl, imm_type, wb_sel, br_f3}
    function automatic logic [14:0] exp_dec(input logic [31:0] i);
        logic       op1;
        logic       op2;
        logic [3:0] alu;
        logic [2:0] imm;
        logic [1:0] wb;
        op1 = 1'b0; op2 = 1'b1; alu = 4'd0; imm = 3'd0; wb = 2'd0;
        case (i[6:0])
            7'b0110011: begin op2 = 1'b0; alu = {i[30], i[14:12]}; end
            7'b0010011: begin imm = 3'd1; alu = {(i[14:12] == 3'b101) ? i[30] : 1'b0, i[14:12]}; end
            7'b0000011: begin imm = 3'd1; wb = 2'd2; end
            7'b0100011: imm = 3'd3;
            7'b1100011: begin op1 = 1'b1; imm = 3'd2; end
            7'b1101111: begin op1 = 1'b1; imm = 3'd4; wb = 2'd1; end
            7'b1100111: begin imm = 3'd1; wb = 2'd1; end
            7'b0110111: begin imm = 3'd5; wb = 2'd3; end
            7'b0010111: begin op1 = 1'b1; imm = 3'd5; end
            default: ;
        endcase
        return {op1, op2, alu, imm, wb, i[14:12]};
    endfunction

    // One instruction: di fetch-wait cycles, dd data-wait cycles, tk branch outcome
    task automatic run_insn(input logic [31:0] insn, input int di, input int dd, input logic tk);
        cyc_t q[$];
        cyc_t c;
        logic is_br, is_jal, is_jalr, is_ld, is_st, jump;
        is_br   = (insn[6:0] == 7'b1100011);
        is_jal  = (insn[6:0] == 7'b1101111);
        is_jalr = (insn[6:0] == 7'b1100111);
        is_ld   = (insn[6:0] == 7'b0000011);
        is_st   = (insn[6:0] == 7'b0100011);
        jump    = is_jal || is_jalr || (is_br && tk);
        for (int k = 0; k < di; k++) begin
            c = '0; c.stb = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); q.push_back(c);
        end
        c = '0; c.irdy = 1'b1; c.stb = mk(1, 1, 1, 2'b00, 0, 0, 0, 0, 0); q.push_back(c);
        c = '0; q.push_back(c);
        c = '0; c.ex = 1'b1;
        c.stb = mk(0, 0, jump, is_jalr ? 2'b10 : (jump ? 2'b01 : 2'b00), 0, 0, 0, is_br, 0);
        q.push_back(c);
        if (is_ld || is_st) begin
            for (int k = 0; k < dd; k++) begin
                c = '0; c.stb = mk(0, 0, 0, 2'b00, 1, is_st, 0, 0, 0); q.push_back(c);
            end
            c = '0; c.drdy = 1'b1; c.stb = mk(0, 0, 0, 2'b00, 1, is_st, 0, 0, 0); q.push_back(c);
        end
        if (!(is_br || is_st)) begin
            c = '0; c.stb = mk(0, 0, 0, 2'b00, 0, 0, 1, 0, 0); q.push_back(c);
        end
        foreach (q[n]) begin
            @(negedge clk);
            if (n == 0) begin
                bus.ir       = insn;
                bus.br_taken = tk;
            end
            bus.imem_rdy = q[n].irdy;
            bus.dmem_rdy = q[n].drdy;
            #1;
            if (n == 0) begin
                check("instret", bus.instret, exp_instret);
                check("flags", 32'({bus.illegal, bus.bus_err}), 32'd0);
            end
            check("strobes", 32'(stb()), 32'(q[n].stb));
            if (q[n].ex) check("decode", 32'(dec_obs()), 32'(exp_dec(insn)));
        end
        exp_instret = exp_instret + 32'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.imem_rdy = 1'b0;
        bus.dmem_rdy = 1'b0;
        #1;
        check("rst_strobes", 32'(stb()), 32'd0);
        check("rst_instret", bus.instret, 32'd0);
        check("rst_flags", 32'({bus.illegal, bus.bus_err}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("req_at_release", 32'(bus.imem_req), 32'd0);
        exp_instret = 32'd0;
    endtask

    initial begin
        logic [31:0] insn;
        int          di;
        int          dd;
        logic        tk;
        rstn = 1'b0;
        bus.ir = 32'd0;
        bus.imem_rdy = 1'b0;
        bus.dmem_rdy = 1'b0;
        bus.br_taken = 1'b0;
        exp_instret = 32'd0;
        repeat (2) @(negedge clk);
        do_reset();

        run_insn(32'h0050_0093, 0, 0, 1'b0);   // ADDI x1,x0,5
        run_insn(32'h0000_0463, 0, 0, 1'b1);   // BEQ taken
        run_insn(32'h0000_1463, 0, 0, 1'b0);   // BNE not taken
        run_insn(32'h0000_2083, 0, 3, 1'b0);   // LW, 3 data waits
        run_insn(32'h0050_0093, TO, 0, 1'b0);  // fetch ready exactly at the limit
        run_insn(32'h0010_2023, 0, TO, 1'b0);  // SW ready exactly at the limit
        run_insn(32'h0080_00EF, 1, 0, 1'b0);   // JAL
        run_insn(32'h0000_80E7, 0, 0, 1'b0);   // JALR

        for (int n = 0; n < 40; n++) begin
            insn = $urandom;
            insn[6:0] = opcs[$urandom_range(0, 9)];
            di = $urandom_range(0, TO);
            dd = $urandom_range(0, TO);
            tk = 1'($urandom_range(0, 1));
            run_insn(insn, di, dd, tk);
        end

        // Fetch never completes: bus error after TO+1 IF cycles
        for (int c = 0; c <= TO; c++) begin
            @(negedge clk);
            bus.ir = 32'h0050_0093;
            bus.imem_rdy = 1'b0;
            #1;
            check("wd_wait", 32'(stb()), 32'(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0)));
        end
        @(negedge clk);
        #1;
        check("wd_halt", 32'(stb()), 32'(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 1)));
        check("wd_flags", 32'({bus.illegal, bus.bus_err}), 32'd1);
        check("wd_instret", bus.instret, exp_instret);

        // Illegal opcode: sticky halt, later fetch-ready ignored
        do_reset();
        @(negedge clk); bus.ir = 32'hFFFF_FFFF; bus.imem_rdy = 1'b1; #1;
        check("ill_fetch", 32'(stb()), 32'(mk(1, 1, 1, 2'b00, 0, 0, 0, 0, 0)));
        @(negedge clk); bus.imem_rdy = 1'b0; #1;
        check("ill_id", 32'(stb()), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); bus.imem_rdy = 1'b1; #1;
            check("ill_halt", 32'(stb()), 32'(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 1)));
        end
        check("ill_flags", 32'({bus.illegal, bus.bus_err}), 32'd2);

        // EBREAK: halt without illegal
        do_reset();
        @(negedge clk); bus.ir = 32'h0010_0073; bus.imem_rdy = 1'b1; #1;
        @(negedge clk); bus.imem_rdy = 1'b0; #1;
        @(negedge clk); bus.imem_rdy = 1'b1; #1;
        check("ebreak_halt", 32'(stb()), 32'(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 1)));
        check("ebreak_flags", 32'({bus.illegal, bus.bus_err}), 32'd0);

        // Reset asserted mid-cycle during a store's MEM phase
        do_reset();
        run_insn(32'h0050_0093, 0, 0, 1'b0);
        @(negedge clk); bus.ir = 32'h0010_2023; bus.imem_rdy = 1'b1; #1;
        check("sw_instret", bus.instret, exp_instret);
        @(negedge clk); bus.imem_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.dmem_rdy = 1'b0; #1;
        check("sw_mem", 32'(stb()), 32'(mk(0, 0, 0, 2'b00, 1, 1, 0, 0, 0)));
        #2 rstn = 1'b0;
        #1;
        check("sw_abort", 32'(stb()), 32'd0);
        check("sw_abort_instret", bus.instret, 32'd0);
        @(negedge clk); rstn = 1'b1; #1;
        check("restart_release", 32'(bus.imem_req), 32'd0);
        @(negedge clk); #1;
        check("restart_if", 32'(stb()), 32'(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
